// File: rtl/cdc_a2s_sync_rx.sv
// cdc_a2s_sync_rx
// Clocked-side receive stage of the async-to-sync CDC. Words arrive on Din
// under the Si/So four-phase level handshake and go into a small FIFO.
// Downstream reads them on a valid/ready interface with first-word
// fall-through. So is registered, and it also acts as backpressure, so the
// CDC never presents a word that the FIFO has no room for.
//
// Optional feature: define CDC_RX_CNT_EN to build the saturating
// accepted-word counter on rx_count. Without it, rx_count is tied to 0.

module cdc_a2s_sync_rx #(
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [DW-1:0]    Din,
    input  logic             Si,
    output logic             So,
    output logic [DW-1:0]    m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] rx_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] STALL  = 2'd2;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [1:0]    state;
    logic [1:0]    state_next;
    logic          push;
    logic          pop;
    logic          space;

    // Handshake qualifiers and the fill level one cycle ahead
    always_comb begin
        push       = Si & So;
        pop        = m_valid & m_ready;
        count_next = count + CW'(push) - CW'(pop);
        space      = (count_next < DEPTH_C);
    end

    assign m_valid = (count != '0);
    assign m_data  = mem[rd_ptr];

    // State decode: So is high only in ACTIVE; STALL records that Si is up but the FIFO is full
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (Si) state_next = space ? ACTIVE : STALL;
            end
            ACTIVE: begin
                if (!Si)        state_next = IDLE;
                else if (!space) state_next = STALL;
            end
            STALL: begin
                if (!Si)       state_next = IDLE;
                else if (space) state_next = ACTIVE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register with a dedicated So flop so the acknowledge is glitch-free
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            So    <= 1'b0;
        end else begin
            state <= state_next;
            So    <= (state_next == ACTIVE);
        end
    end

    // Pointers wrap naturally; the separate count register tells full from empty
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Storage is cleared on reset so that m_data reads 0 until the first word lands
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= Din;
        end
    end

`ifdef CDC_RX_CNT_EN
    // Accepted-word counter, holds at all-ones instead of wrapping
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_count <= '0;
        end else if (push && (rx_count != {CNT_W{1'b1}})) begin
            rx_count <= rx_count + CNT_W'(1);
        end
    end
`else
    assign rx_count = '0;
`endif

endmodule

// File: tb/tb_cdc_a2s_sync_rx.sv
// tb_cdc_a2s_sync_rx
// Directed bench for cdc_a2s_sync_rx. The expected rx_count values depend on
// whether CDC_RX_CNT_EN is defined.

module tb_cdc_a2s_sync_rx;

    logic        CLK;
    logic        RESET;
    logic [63:0] Din;
    logic        Si;
    logic        So;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] rx_count;

    int checks = 0;
    int errors = 0;

    cdc_a2s_sync_rx #(.DW(64), .DEPTH(4), .CNT_W(32)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Din      (Din),
        .Si       (Si),
        .So       (So),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .rx_count (rx_count)
    );

    // Free-running 10-unit clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [63:0] expCnt(input int n);
`ifdef CDC_RX_CNT_EN
        return 64'(n);
`else
        return 64'(n - n);
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic si, input logic [63:0] din, input logic rdy);
        Si      = si;
        Din     = din;
        m_ready = rdy;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int modelCount;
        bit modelSo;
        int pushed;
        int popped;
        int cyc;
        bit doPush;
        bit doPop;

        RESET = 1'b1;
        applyStimulus(1'b0, 64'd0, 1'b0);
        tick();
        tick();
        RESET = 1'b0;

        // Reset values
        checkOutput("rst_So", So, 0);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_m_data", m_data, 0);
        checkOutput("rst_rx_count", rx_count, 0);

        // Single word
        applyStimulus(1'b1, 64'hDEADBEEF_00000001, 1'b1);
        tick();
        checkOutput("single_So_rise", So, 1);
        checkOutput("single_no_early_valid", m_valid, 0);
        tick();
        checkOutput("single_m_valid", m_valid, 1);
        checkOutput("single_m_data", m_data, 64'hDEADBEEF_00000001);
        checkOutput("single_rx_count", rx_count, expCnt(1));
        checkOutput("single_So_hold", So, 1);
        applyStimulus(1'b0, 64'd0, 1'b1);
        tick();
        checkOutput("single_So_fall", So, 0);
        checkOutput("single_drained", m_valid, 0);

        // Streaming 0..15
        applyStimulus(1'b1, 64'd0, 1'b1);
        tick();
        checkOutput("stream_So_rise", So, 1);
        for (int k = 0; k < 16; k++) begin
            tick();
            checkOutput($sformatf("stream_data%0d", k), m_data, 64'(k));
            checkOutput($sformatf("stream_So%0d", k), So, 1);
            applyStimulus((k < 15), 64'(k + 1), 1'b1);
        end
        tick();
        checkOutput("stream_So_fall", So, 0);
        checkOutput("stream_drained", m_valid, 0);
        checkOutput("stream_rx_count", rx_count, expCnt(17));

        // Backpressure: exactly four pushes, then STALL
        applyStimulus(1'b1, 64'd100, 1'b0);
        tick();
        checkOutput("bp_So_rise", So, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("bp_So_push%0d", i), So, (i < 3));
            checkOutput($sformatf("bp_head%0d", i), m_data, 64'd100);
            applyStimulus(1'b1, 64'(101 + i), 1'b0);
        end
        tick();
        checkOutput("bp_stall_So", So, 0);
        checkOutput("bp_stall_head", m_data, 64'd100);
        applyStimulus(1'b1, 64'd104, 1'b1);
        tick();
        checkOutput("bp_pop_So", So, 1);
        checkOutput("bp_pop_head", m_data, 64'd101);
        applyStimulus(1'b1, 64'd104, 1'b0);
        tick();
        checkOutput("bp_fifth_So", So, 0);
        checkOutput("bp_fifth_count", rx_count, expCnt(22));
        applyStimulus(1'b0, 64'd0, 1'b1);
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("bp_drain%0d", j), m_data, 64'(101 + j));
            tick();
        end
        checkOutput("bp_drained", m_valid, 0);

        // Wrap-around with m_ready toggling; 10 words starting at 200
        modelCount = 0;
        modelSo    = 1'b0;
        pushed     = 0;
        popped     = 0;
        cyc        = 0;
        while ((pushed < 10 || modelCount > 0) && cyc < 200) begin
            applyStimulus((pushed < 10), 64'(200 + pushed), ((cyc % 2) == 0));
            checkOutput($sformatf("wrap_So_c%0d", cyc), So, modelSo);
            checkOutput($sformatf("wrap_valid_c%0d", cyc), m_valid, (modelCount > 0));
            doPush = Si && modelSo;
            doPop  = (modelCount > 0) && m_ready;
            if (doPop) checkOutput($sformatf("wrap_data%0d", popped), m_data, 64'(200 + popped));
            tick();
            modelCount = modelCount + int'(doPush) - int'(doPop);
            if (doPush) pushed++;
            if (doPop)  popped++;
            modelSo = Si && (modelCount < 4);
            cyc++;
        end
        checkOutput("wrap_pushed", 64'(pushed), 64'd10);
        checkOutput("wrap_popped", 64'(popped), 64'd10);
        checkOutput("wrap_rx_count", rx_count, expCnt(32));

        // Reset mid-stream after 2 of 4 words
        applyStimulus(1'b1, 64'd300, 1'b0);
        tick();
        tick();
        applyStimulus(1'b1, 64'd301, 1'b0);
        tick();
        checkOutput("mid_pre_valid", m_valid, 1);
        #2;
        RESET = 1'b1;
        #1;
        checkOutput("mid_rst_So", So, 0);
        checkOutput("mid_rst_valid", m_valid, 0);
        checkOutput("mid_rst_data", m_data, 0);
        checkOutput("mid_rst_count", rx_count, 0);
        applyStimulus(1'b0, 64'd0, 1'b0);
        tick();
        tick();
        RESET = 1'b0;
        applyStimulus(1'b1, 64'hA5A5A5A5_A5A5A5A5, 1'b1);
        tick();
        checkOutput("fresh_So", So, 1);
        checkOutput("fresh_not_valid", m_valid, 0);
        tick();
        checkOutput("fresh_valid", m_valid, 1);
        checkOutput("fresh_data", m_data, 64'hA5A5A5A5_A5A5A5A5);
        checkOutput("fresh_rx_count", rx_count, expCnt(1));
        applyStimulus(1'b0, 64'd0, 1'b1);
        tick();
        checkOutput("fresh_So_fall", So, 0);
        checkOutput("fresh_drained", m_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
